// File: rtl/spi_sb_xfer_ctrl.sv
// Sequencer for the iCE40 SB_SPI hard-IP system bus: configures the IP after IPDONE,
// then turns fabric byte requests into CS / TXDR / SR-poll / RXDR bus accesses.
module spi_sb_xfer_ctrl #(
  parameter logic [3:0] BASE_NIB = 4'b0010,
  parameter logic [7:0] CR0_VAL  = 8'hFF,
  parameter logic [7:0] CR1_VAL  = 8'h80,
  parameter logic [7:0] CR2_VAL  = 8'hC0,
  parameter logic [7:0] BR_VAL   = 8'h3F,
  parameter logic [7:0] CS_ON    = 8'h0E,
  parameter int         ACK_TMO  = 16,
  parameter int         POLL_MAX = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ipdone,
  output logic       cfg_done,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  input  logic       req_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err,
  output logic       sb_stb,
  output logic       sb_wr,
  output logic [7:0] sb_addr,
  output logic [7:0] sb_wdata,
  input  logic [7:0] sb_rdata,
  input  logic       sb_ack,
  output logic       cs_active,
  output logic [3:0] fsm_state
);

  localparam logic [7:0] CS_OFF_VAL = 8'h0F;
  localparam int TMO_W  = $clog2(ACK_TMO + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TMO - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

  typedef enum logic [3:0] {
    ST_WAIT_IP = 4'd0,
    ST_CFG     = 4'd1,
    ST_IDLE    = 4'd2,
    ST_CS_ON   = 4'd3,
    ST_TX      = 4'd4,
    ST_POLL    = 4'd5,
    ST_RX      = 4'd6,
    ST_CS_OFF  = 4'd7,
    ST_FAULT   = 4'd8
  } state_t;

  state_t            state_q, state_n;
  logic              gap_q, gap_n;
  logic [TMO_W-1:0]  tmo_q, tmo_n;
  logic [POLL_W-1:0] poll_q, poll_n;
  logic [2:0]        cfg_idx_q, cfg_idx_n;
  logic [7:0]        data_q, data_n;
  logic              last_q, last_n;
  logic              cs_q, cs_n;
  logic              err_q, err_n;
  logic              done_q, done_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic [7:0]        rsp_data_q, rsp_data_n;
  logic              rrdy_q, rrdy_n;

  logic              acc_en, acc_wr;
  logic [3:0]        acc_reg;
  logic [7:0]        acc_wdata;

  // Bus access decode: each access state owns one register address; gap_q marks the idle cycle after ack.
  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = 1'b0;
    acc_reg   = 4'h0;
    acc_wdata = 8'h00;
    case (state_q)
      ST_CFG: begin
        acc_en = 1'b1;
        acc_wr = 1'b1;
        case (cfg_idx_q)
          3'd0:    begin acc_reg = 4'h8; acc_wdata = CR0_VAL;    end
          3'd1:    begin acc_reg = 4'h9; acc_wdata = CR1_VAL;    end
          3'd2:    begin acc_reg = 4'hA; acc_wdata = CR2_VAL;    end
          3'd3:    begin acc_reg = 4'hB; acc_wdata = BR_VAL;     end
          default: begin acc_reg = 4'hF; acc_wdata = CS_OFF_VAL; end
        endcase
      end
      ST_CS_ON:  begin acc_en = 1'b1; acc_wr = 1'b1; acc_reg = 4'hF; acc_wdata = CS_ON;      end
      ST_TX:     begin acc_en = 1'b1; acc_wr = 1'b1; acc_reg = 4'hD; acc_wdata = data_q;     end
      ST_POLL:   begin acc_en = 1'b1; acc_reg = 4'hC;                                        end
      ST_RX:     begin acc_en = 1'b1; acc_reg = 4'hE;                                        end
      ST_CS_OFF: begin acc_en = 1'b1; acc_wr = 1'b1; acc_reg = 4'hF; acc_wdata = CS_OFF_VAL; end
      default:   ;
    endcase
  end

  always_comb begin
    state_n     = state_q;
    gap_n       = gap_q;
    tmo_n       = tmo_q;
    poll_n      = poll_q;
    cfg_idx_n   = cfg_idx_q;
    data_n      = data_q;
    last_n      = last_q;
    cs_n        = cs_q;
    err_n       = err_q;
    done_n      = done_q;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;
    rrdy_n      = rrdy_q;
    if (acc_en && !gap_q) begin
      if (sb_ack) begin
        gap_n  = 1'b1;
        tmo_n  = '0;
        rrdy_n = sb_rdata[3];
        if (state_q == ST_RX) begin
          rsp_valid_n = 1'b1;
          rsp_data_n  = sb_rdata;
        end
      end else if (tmo_q == TMO_LAST) begin
        state_n = ST_FAULT;
        err_n   = 1'b1;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo_q + 1'b1;
      end
    end else begin
      // Idle cycle after an acked access (or a non-access state): decide what comes next.
      gap_n = 1'b0;
      case (state_q)
        ST_WAIT_IP: if (ipdone) begin
          state_n   = ST_CFG;
          cfg_idx_n = 3'd0;
        end
        ST_CFG: if (cfg_idx_q == 3'd4) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cfg_idx_n = cfg_idx_q + 3'd1;
        end
        ST_IDLE: if (req_valid) begin
          data_n  = req_data;
          last_n  = req_last;
          state_n = cs_q ? ST_TX : ST_CS_ON;
        end
        ST_CS_ON: begin
          cs_n    = 1'b1;
          state_n = ST_TX;
        end
        ST_TX: begin
          poll_n  = '0;
          state_n = ST_POLL;
        end
        ST_POLL: if (rrdy_q) begin
          state_n = ST_RX;
        end else if (poll_q == POLL_LAST) begin
          err_n   = 1'b1;
          state_n = ST_FAULT;
        end else begin
          poll_n = poll_q + 1'b1;
        end
        ST_RX:     state_n = last_q ? ST_CS_OFF : ST_IDLE;
        ST_CS_OFF: begin
          cs_n    = 1'b0;
          state_n = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_IP;
      gap_q       <= 1'b0;
      tmo_q       <= '0;
      poll_q      <= '0;
      cfg_idx_q   <= 3'd0;
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      cs_q        <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rrdy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      gap_q       <= gap_n;
      tmo_q       <= tmo_n;
      poll_q      <= poll_n;
      cfg_idx_q   <= cfg_idx_n;
      data_q      <= data_n;
      last_q      <= last_n;
      cs_q        <= cs_n;
      err_q       <= err_n;
      done_q      <= done_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rrdy_q      <= rrdy_n;
    end
  end

  // Bus fields are zero whenever no access is in flight, so the bus is quiet between accesses.
  assign sb_stb    = acc_en && !gap_q;
  assign sb_wr     = sb_stb && acc_wr;
  assign sb_addr   = sb_stb ? {BASE_NIB, acc_reg} : 8'h00;
  assign sb_wdata  = sb_stb ? acc_wdata : 8'h00;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cfg_done  = done_q;
  assign err       = err_q;
  assign cs_active = cs_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_sb_xfer_ctrl.sv
// Bench for spi_sb_xfer_ctrl: reactive SB slave model, access/response scoreboard queues.
module tb_spi_sb_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ipdone = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_last = 1'b0;
  logic [7:0] sb_rdata = 8'h00;
  logic       sb_ack = 1'b0;
  logic       cfg_done, req_ready, rsp_valid, err, sb_stb, sb_wr, cs_active;
  logic [7:0] rsp_data, sb_addr, sb_wdata;
  logic [3:0] fsm_state;

  localparam int POLL_MAX = 1024;

  always #5 clk = ~clk;

  spi_sb_xfer_ctrl dut (
    .clk(clk), .reset(reset), .ipdone(ipdone), .cfg_done(cfg_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
    .sb_stb(sb_stb), .sb_wr(sb_wr), .sb_addr(sb_addr), .sb_wdata(sb_wdata),
    .sb_rdata(sb_rdata), .sb_ack(sb_ack), .cs_active(cs_active), .fsm_state(fsm_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  rsp_q[$];

  int         ack_dly = 2;
  logic [7:0] noack_addr = 8'h00;
  int         rrdy_at = 3;
  int         sr_cnt = 0;
  int         sr_total = 0;
  int         stb_cnt = 0;
  int         last_run = 0;
  int         rsp_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  bit         cs_model = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SB slave model plus monitors; everything happens on the falling edge.
  always @(negedge clk) begin
    logic [7:0]  rd;
    logic [16:0] got;
    logic [16:0] exp;
    logic [7:0]  rexp;
    if (reset) begin
      sb_ack  = 1'b0;
      stb_cnt = 0;
    end else if (sb_stb) begin
      stb_cnt++;
      if (stb_cnt > ack_dly && sb_addr != noack_addr) begin
        rd = 8'h00;
        if (!sb_wr) begin
          if (sb_addr[3:0] == 4'hC) begin
            sr_total++;
            sr_cnt++;
            if (rrdy_at != 0 && sr_cnt == rrdy_at) begin
              rd = 8'h08;
              sr_cnt = 0;
            end
          end else if (sb_addr[3:0] == 4'hE) begin
            rd = last_tx ^ 8'hFF;
          end
        end else if (sb_addr[3:0] == 4'hD) begin
          last_tx = sb_wdata;
        end
        sb_rdata = rd;
        sb_ack   = 1'b1;
        got = {sb_wr, sb_addr, sb_wr ? sb_wdata : rd};
        check_eq("sb_pending", exp_q.size() != 0, 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
        check_eq("sb_access", got, exp);
      end
    end else begin
      if (stb_cnt != 0) last_run = stb_cnt;
      stb_cnt = 0;
      sb_ack  = 1'b0;
    end
    if (rsp_valid && !reset) begin
      rsp_cnt++;
      check_eq("rsp_pending", rsp_q.size() != 0, 1);
      rexp = (rsp_q.size() != 0) ? rsp_q.pop_front() : 8'h00;
      check_eq("rsp_data", rsp_data, rexp);
    end
  end

  task automatic push_acc(input bit wr, input logic [3:0] lo, input logic [7:0] d);
    exp_q.push_back({wr, 4'h2, lo, d});
  endtask

  task automatic push_cfg();
    push_acc(1'b1, 4'h8, 8'hFF);
    push_acc(1'b1, 4'h9, 8'h80);
    push_acc(1'b1, 4'hA, 8'hC0);
    push_acc(1'b1, 4'hB, 8'h3F);
    push_acc(1'b1, 4'hF, 8'h0F);
  endtask

  // rr = SR read on which RRDY appears; 0 means never (POLL_MAX reads then fault).
  task automatic push_byte(input logic [7:0] d, input bit last, input int rr);
    if (!cs_model) push_acc(1'b1, 4'hF, 8'h0E);
    cs_model = 1'b1;
    push_acc(1'b1, 4'hD, d);
    if (rr == 0) begin
      for (int i = 0; i < POLL_MAX; i++) push_acc(1'b0, 4'hC, 8'h00);
    end else begin
      for (int i = 0; i < rr; i++) push_acc(1'b0, 4'hC, (i == rr - 1) ? 8'h08 : 8'h00);
      push_acc(1'b0, 4'hE, d ^ 8'hFF);
      rsp_q.push_back(d ^ 8'hFF);
      if (last) begin
        push_acc(1'b1, 4'hF, 8'h0F);
        cs_model = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input bit last, input int rr);
    bit acc;
    acc = 1'b0;
    rrdy_at = rr;
    push_byte(d, last, rr);
    @(negedge clk);
    req_data  = d;
    req_last  = last;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (req_ready) acc = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("req_accept", acc, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || rsp_q.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("drain_acc", exp_q.size(), 0);
    check_eq("drain_rsp", rsp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_stb"}, sb_stb, 0);
    check_eq({tag, "_wr"}, sb_wr, 0);
    check_eq({tag, "_addr"}, sb_addr, 0);
    check_eq({tag, "_wdata"}, sb_wdata, 0);
    check_eq({tag, "_ready"}, req_ready, 0);
    check_eq({tag, "_rspv"}, rsp_valid, 0);
    check_eq({tag, "_rspd"}, rsp_data, 0);
    check_eq({tag, "_cfgdone"}, cfg_done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_cs"}, cs_active, 0);
    check_eq({tag, "_state"}, fsm_state, 0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    rsp_q.delete();
    cs_model = 1'b0;
    sr_cnt   = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ipdone = 1'b0;
    req_valid = 1'b0;
    flush_model();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
  endtask

  task automatic wait_cfg(input int budget);
    for (int i = 0; i < budget && !cfg_done; i++) @(negedge clk);
    check_eq("cfg_done", cfg_done, 1);
    check_eq("cfg_acc_left", exp_q.size(), 0);
    check_eq("cfg_state_idle", fsm_state, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, requests ignored before IPDONE, config sequence.
    do_reset();
    req_valid = 1'b1;
    req_data  = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("ready_before_ip", req_ready, 0);
    end
    req_valid = 1'b0;
    check_eq("state_wait_ip", fsm_state, 0);
    push_cfg();
    ipdone = 1'b1;
    wait_cfg(300);

    // Single-byte frame, RRDY on 3rd SR read.
    send(8'hA5, 1'b1, 3);
    wait_drain(500);
    check_eq("cs_after_frame", cs_active, 0);

    // Three-byte frame: CS stays asserted between bytes.
    send(8'h11, 1'b0, 1);
    wait_drain(500);
    check_eq("cs_mid_frame", cs_active, 1);
    send(8'h22, 1'b0, 2);
    wait_drain(500);
    send(8'h33, 1'b1, $urandom_range(4, 1));
    wait_drain(500);
    check_eq("cs_end_frame", cs_active, 0);
    check_eq("state_idle", fsm_state, 2);

    // RRDY never set: POLL_MAX reads then fault.
    sr_total = 0;
    rsp_cnt  = 0;
    send(8'h5C, 1'b1, 0);
    for (int i = 0; i < 20000 && !err; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("poll_err", err, 1);
    check_eq("poll_reads", sr_total, POLL_MAX);
    check_eq("poll_no_rsp", rsp_cnt, 0);
    check_eq("poll_acc_left", exp_q.size(), 0);
    check_eq("fault_state", fsm_state, 8);
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("fault_ready", req_ready, 0);
    check_eq("fault_stb", sb_stb, 0);
    req_valid = 1'b0;

    // Reset asserted mid-POLL, then full re-config.
    do_reset();
    push_cfg();
    ipdone = 1'b1;
    wait_cfg(300);
    sr_total = 0;
    send(8'h77, 1'b1, 0);
    for (int i = 0; i < 2000 && sr_total < 5; i++) @(negedge clk);
    check_eq("in_poll", fsm_state, 5);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    flush_model();
    push_cfg();
    @(negedge clk);
    reset = 1'b0;
    wait_cfg(300);
    send(8'hC3, 1'b1, 1);
    wait_drain(500);

    // CR1 never acked: timeout after ACK_TMO cycles.
    do_reset();
    noack_addr = 8'h29;
    push_acc(1'b1, 4'h8, 8'hFF);
    ipdone = 1'b1;
    for (int i = 0; i < 300 && !err; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_stb_len", last_run, 16);
    check_eq("tmo_stb_low", sb_stb, 0);
    check_eq("tmo_cfg_done", cfg_done, 0);
    check_eq("tmo_acc_left", exp_q.size(), 0);
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("tmo_ready", req_ready, 0);
    req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
